ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
- Sequences the 16x8 dual-port RAM as a synchronous FIFO.
- Converts push/pop requests into RAM write/read enables and addresses, tracks occupancy, and flags full/empty.
- Produces a read-valid strobe aligned with the RAM's registered dout.
- Data does not pass through this block: push data wires straight to RAM din, and RAM dout is the FIFO output.

Parameters:
- ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W (16).
- AF_LEVEL, 14, almost-full threshold (optional feature only).
- AE_LEVEL, 2, almost-empty threshold (optional feature only).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  request to write RAM din at the current write pointer.
- pop  in  1  request to read the entry at the current read pointer.
- wr_en  out  1  RAM write enable (combinational: push & ~full).
- wr_addr  out  ADDR_W  RAM write address = write pointer.
- rd_en  out  1  RAM read enable (combinational: pop & ~empty).
- rd_addr  out  ADDR_W  RAM read address = read pointer.
- rd_valid  out  1  registered; high the cycle RAM dout holds popped data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, immediate on rst high):
  - Write pointer, read pointer and count = 0.
  - empty=1, full=0, rd_valid=0, overflow=0, underflow=0.
  - wr_en and rd_en = 0 while rst is high.
- full and empty decode the registered count, so they never depend combinationally on push/pop.
- Accepted push: wr_en=1 this cycle; write pointer increments at the clock edge.
- Accepted pop: rd_en=1 this cycle; read pointer increments at the clock edge; rd_valid=1 the following cycle (RAM read latency is 1 cycle).
- Pointer wrap: DEPTH-1 -> 0 via natural ADDR_W-bit rollover.
- count update per edge:
  - +1 on push-only accept.
  - -1 on pop-only accept.
  - Unchanged on both accepted or neither accepted.
- Push while full:
  - wr_en=0; pointer and count unchanged.
  - overflow set and held until reset.
- Pop while empty:
  - rd_en=0; rd_valid=0 next cycle.
  - underflow set and held until reset.
- Simultaneous push and pop:
  - When empty: push accepted, pop rejected (no bypass); underflow set.
  - When full: pop accepted, push rejected; overflow set.
  - Otherwise: both accepted, count holds. wr_addr and rd_addr differ, so no RAM collision.
- Reset mid-operation: all state clears at once. An in-flight rd_valid is dropped, and RAM contents are not cleared (no reset on the RAM).
- No FSM beyond pointer/count state. Occupancy is never derived from pointer difference alone, because count disambiguates full from empty.

Optional Feature:
- Macro: RAM_FIFO_ALMOST_FLAGS_EN.
- Defined:
  - Adds outputs almost_full (count >= AF_LEVEL) and almost_empty (count <= AE_LEVEL).
  - Both decode the registered count, so they update in the same cycle as count.
  - Reset values: almost_full=0, almost_empty=1.
- Undefined: neither port exists and AF_LEVEL/AE_LEVEL are unused; all other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles mid-clock -> count=0, empty=1, full=0, rd_valid=0, overflow=0, underflow=0 immediately, without waiting for a clock edge.
- Fill: 16 pushes with din=0..15 -> wr_addr 0..15, wr_en high each cycle; after the 16th, full=1, count=16. A 17th push gives wr_en=0, overflow=1, count=16.
- Drain: 16 pops from full -> rd_addr 0..15; rd_valid one cycle after each rd_en; dout=0..15 in order; ending empty=1, count=0. A 17th pop gives rd_en=0, underflow=1.
- Wrap: push 10, pop 10, push 10 -> second burst wr_addr 10..15, 0..3; later pops read rd_addr 10..15, 0..3 and return the matching data.
- Simultaneous push+pop:
  - At count=5 -> wr_en=1, rd_en=1, count stays 5.
  - At count=0 -> only wr_en=1, count becomes 1, underflow=1.
  - At count=16 -> only rd_en=1, count becomes 15, overflow=1.
- Reset mid-stream: after 6 pushes and 1 pop issued, assert rst in the cycle after the pop -> rd_valid forced 0. A post-reset push writes wr_addr=0.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_ctrl
// Description : Synchronous FIFO controller for a 16x8 dual-port RAM with a
//               registered read port. It generates write/read enables and
//               addresses, tracks occupancy, and drives full/empty, sticky
//               overflow/underflow and a read-valid strobe.
//               The optional almost_full/almost_empty outputs are enabled by
//               defining RAM_FIFO_ALMOST_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam logic [ADDR_W:0]   c_DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   c_CNT_ZERO  = '0;
    localparam logic [ADDR_W:0]   c_CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE   = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;

    // Flags come only from the registered count, never from push/pop.
    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == c_CNT_ZERO);

    // Enables are gated by rst so the RAM sees no access during reset.
    assign w_wr_acc = push & ~w_full  & ~rst;
    assign w_rd_acc = pop  & ~w_empty & ~rst;

    assign wr_en     = w_wr_acc;
    assign rd_en     = w_rd_acc;
    assign wr_addr   = r_wr_ptr;
    assign rd_addr   = r_rd_ptr;
    assign rd_valid  = r_rd_valid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            // RAM dout is registered, so data for a pop appears one cycle later.
            r_rd_valid <= w_rd_acc;
            if (push && w_full) begin
                r_overflow <= 1'b1;
            end
            if (pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef RAM_FIFO_ALMOST_FLAGS_EN
    localparam logic [ADDR_W:0] c_AF_LEVEL = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] c_AE_LEVEL = (ADDR_W+1)'(AE_LEVEL);

    assign almost_full  = (r_count >= c_AF_LEVEL);
    assign almost_empty = (r_count <= c_AE_LEVEL);
`else
    logic w_unused_levels;
    assign w_unused_levels = (AF_LEVEL > 0) ^ (AE_LEVEL > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_fifo_ctrl
// Description : Directed bench for ram_fifo_ctrl with a queue-based FIFO model
//               and a behavioural 16x8 registered-read RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;

    localparam int c_ADDR_W = 4;
    localparam int c_DEPTH  = 16;

    logic                clk;
    logic                rst;
    logic                push;
    logic                pop;
    logic [7:0]          din;
    logic                wr_en;
    logic [c_ADDR_W-1:0] wr_addr;
    logic                rd_en;
    logic [c_ADDR_W-1:0] rd_addr;
    logic                rd_valid;
    logic                full;
    logic                empty;
    logic [c_ADDR_W:0]   count;
    logic                overflow;
    logic                underflow;
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
    logic                almost_full;
    logic                almost_empty;
`endif

    ram_fifo_ctrl #(.ADDR_W(c_ADDR_W), .AF_LEVEL(14), .AE_LEVEL(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: no reset, registered read.
    logic [7:0] mem [c_DEPTH];
    logic [7:0] dout;
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= din;
        if (rd_en) dout <= mem[rd_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // FIFO model: contents in a queue, addresses from accepted-operation totals.
    logic [7:0] m_q [$];
    int         m_npush = 0;
    int         m_npop  = 0;
    bit         m_rv    = 1'b0;
    bit         m_ovf   = 1'b0;
    bit         m_unf   = 1'b0;
    logic [7:0] m_data  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_npush = 0;
            m_npop  = 0;
            m_rv    = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            automatic int  sz   = m_q.size();
            automatic bit  do_w = push && (sz < c_DEPTH);
            automatic bit  do_r = pop && (sz > 0);
            if (push && sz == c_DEPTH) m_ovf = 1'b1;
            if (pop && sz == 0)        m_unf = 1'b1;
            m_rv = do_r;
            if (do_r) begin
                m_data = m_q.pop_front();
                m_npop++;
            end
            if (do_w) begin
                m_q.push_back(din);
                m_npush++;
            end
        end
    end

    always @(negedge clk) begin
        automatic int sz = m_q.size();
        chk("wr_en",     {31'd0, wr_en},     {31'd0, (!rst && push && sz < c_DEPTH)});
        chk("rd_en",     {31'd0, rd_en},     {31'd0, (!rst && pop && sz > 0)});
        chk("wr_addr",   {28'd0, wr_addr},   m_npush % c_DEPTH);
        chk("rd_addr",   {28'd0, rd_addr},   m_npop % c_DEPTH);
        chk("count",     {27'd0, count},     sz);
        chk("full",      {31'd0, full},      {31'd0, (sz == c_DEPTH)});
        chk("empty",     {31'd0, empty},     {31'd0, (sz == 0)});
        chk("rd_valid",  {31'd0, rd_valid},  {31'd0, m_rv});
        chk("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
        chk("underflow", {31'd0, underflow}, {31'd0, m_unf});
        if (m_rv) chk("dout", {24'd0, dout}, {24'd0, m_data});
`ifdef RAM_FIFO_ALMOST_FLAGS_EN
        chk("almost_full",  {31'd0, almost_full},  {31'd0, (sz >= 14)});
        chk("almost_empty", {31'd0, almost_empty}, {31'd0, (sz <= 2)});
`endif
    end

    // Inputs change 1 time unit after the rising edge.
    task automatic step(input bit p, input bit q, input logic [7:0] d);
        push = p;
        pop  = q;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_count",     {27'd0, count},     32'd0);
        chk("rst_empty",     {31'd0, empty},     32'd1);
        chk("rst_full",      {31'd0, full},      32'd0);
        chk("rst_rd_valid",  {31'd0, rd_valid},  32'd0);
        chk("rst_overflow",  {31'd0, overflow},  32'd0);
        chk("rst_underflow", {31'd0, underflow}, 32'd0);
        push = 1'b0;
        pop  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        din  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("init_count", {27'd0, count}, 32'd0);
        chk("init_empty", {31'd0, empty}, 32'd1);

        // Fill then overflow
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
        chk("fill_count", {27'd0, count}, 32'd16);
        chk("fill_full",  {31'd0, full},  32'd1);
        push = 1'b1;
        #1 chk("push_full_wr_en", {31'd0, wr_en}, 32'd0);
        @(posedge clk);
        #1 push = 1'b0;
        chk("ovf_set",   {31'd0, overflow}, 32'd1);
        chk("ovf_count", {27'd0, count},    32'd16);

        // Drain then underflow
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_last_dout", {24'd0, dout}, 32'd15);
        pop = 1'b1;
        #1 chk("pop_empty_rd_en", {31'd0, rd_en}, 32'd0);
        @(posedge clk);
        #1 pop = 1'b0;
        chk("unf_set", {31'd0, underflow}, 32'd1);

        // Reset mid-stream: 6 pushes, 1 pop, reset while rd_valid is high
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        step(1'b0, 1'b1, 8'h00);
        chk("pre_rst_rd_valid", {31'd0, rd_valid}, 32'd1);
        do_reset();
        push = 1'b1;
        din  = 8'hA5;
        #1 chk("post_rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        @(posedge clk);
        #1 push = 1'b0;
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Wrap
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
        push = 1'b1;
        din  = 8'h80;
        #1 chk("wrap_wr_addr_first", {28'd0, wr_addr}, 32'd10);
        @(posedge clk);
        #1;
        for (int i = 1; i < 10; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
        chk("wrap_wr_addr_next", {28'd0, wr_addr}, 32'd4);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("wrap_last_dout", {24'd0, dout}, 32'h89);

        // Simultaneous push and pop
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
        push = 1'b1;
        pop  = 1'b1;
        din  = 8'h25;
        #1;
        chk("pp5_wr_en", {31'd0, wr_en}, 32'd1);
        chk("pp5_rd_en", {31'd0, rd_en}, 32'd1);
        @(posedge clk);
        #1 chk("pp5_count", {27'd0, count}, 32'd5);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
        push = 1'b1;
        pop  = 1'b1;
        din  = 8'h30;
        #1;
        chk("pp0_wr_en", {31'd0, wr_en}, 32'd1);
        chk("pp0_rd_en", {31'd0, rd_en}, 32'd0);
        @(posedge clk);
        #1;
        chk("pp0_count", {27'd0, count},     32'd1);
        chk("pp0_unf",   {31'd0, underflow}, 32'd1);
        for (int i = 1; i < 16; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
        push = 1'b1;
        pop  = 1'b1;
        din  = 8'hEE;
        #1;
        chk("pp16_wr_en", {31'd0, wr_en}, 32'd0);
        chk("pp16_rd_en", {31'd0, rd_en}, 32'd1);
        @(posedge clk);
        #1;
        chk("pp16_count", {27'd0, count},    32'd15);
        chk("pp16_ovf",   {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("final_empty", {31'd0, empty}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
